ser2par_sync: RTL and testbench
===============================

Name: ser2par_sync

Overview:
- Receive-side neighbour of the conditional serial flop stage: consumes the serial bit stream (D plus valid_in) that stage drives.
- Finds byte alignment by hunting for the comma character COMMA and locks after COMMA_COUNT consecutive aligned commas.
- Once locked, deserialises MSB-first bytes onto a parallel bus with a one-cycle valid pulse per data byte; commas are flagged as idle.

Parameters:
WIDTH, 8, parallel word width; serial bits per word
COMMA, 8'hBC, alignment/idle character (K28.5 payload)
COMMA_COUNT, 4, consecutive aligned commas required to enter LOCKED (legal range 1..15)

Ports:
CLK  input  1  clock; all state updates on posedge
RESET  input  1  synchronous, active-high reset
D  input  1  serial data bit, MSB of each word first
valid_in  input  1  D is a valid bit this cycle; when low, all state holds
data_out  output  WIDTH  last completed word while LOCKED
valid_out  output  1  one-cycle pulse: data_out holds a non-comma word
active  output  1  high while in LOCKED

Behaviour:
- Synchronous active-high reset, single clock domain.
- Reset, sampled at posedge: state=SEARCH, shift reg sr=0, bit_cnt=0, bc_cnt=0, data_out=0, valid_out=0, active=0.
- RESET has priority over every other input, including mid-word and mid-lock.
- next_sr = {sr[WIDTH-2:0], D}. Computed combinationally and used for all compares on the same edge. sr <= next_sr only when valid_in=1.
- valid_in=0:
  - sr, bit_cnt, bc_cnt, state and data_out hold.
  - valid_out forced 0 (a pulse never stretches across a gap).
- SEARCH (bit-granular hunt, active=0), on each valid bit:
  - If next_sr==COMMA: bit_cnt<=0, bc_cnt<=1, next state is ALIGN, or LOCKED if COMMA_COUNT==1.
  - Otherwise stay in SEARCH.
- ALIGN (active=0), on each valid bit:
  - bit_cnt increments, wrapping 0..WIDTH-1. A word boundary is the valid bit taken while bit_cnt==WIDTH-1.
  - At a boundary with next_sr==COMMA: bc_cnt++. If the incremented value equals COMMA_COUNT, go to LOCKED.
  - At a boundary with next_sr!=COMMA: bc_cnt<=0, go to SEARCH. The hunt restarts on the next valid bit; no bits are replayed.
- LOCKED (active=1), on each valid bit:
  - bit_cnt wraps 0..WIDTH-1.
  - At a word boundary: data_out<=next_sr, valid_out<=(next_sr!=COMMA).
  - All other cycles: valid_out<=0.
  - LOCKED exits only on RESET.
- Latency: the word whose LSB is sampled at edge N appears on data_out/valid_out right after edge N. Registered outputs, zero extra pipeline stages.
- active is registered: it rises on the edge that completes the COMMA_COUNT-th aligned comma and falls on the reset edge.
- The locking comma itself does not produce a data_out update. The first data_out update is at the next word boundary.
- A comma pattern straddling a boundary while LOCKED is ignored; no realignment.
- Width rules: bit_cnt is clog2(WIDTH) bits; bc_cnt is 4 bits and saturates at COMMA_COUNT.

Test Plan:
- Reset: RESET=1 for 2 cycles with random D/valid_in -> data_out=8'h00, valid_out=0, active=0 on every edge.
- Lock at odd offset: bits 1,0,1 then 4×8'hBC MSB-first, valid_in=1 -> active rises on the edge of the 35th bit; valid_out stays 0 throughout.
- Data after lock: send 8'hA5 then 8'h3C -> valid_out pulses once per byte, data_out=A5 then 3C, each visible after the edge of the byte's LSB.
- Idle while locked: send 8'hBC -> data_out=8'hBC, valid_out=0, active stays 1.
- Alignment failure: 3×8'hBC then 8'h00 with COMMA_COUNT=4 -> back to SEARCH, active=0; a subsequent 4×BC locks normally.
- Gaps and reset mid-lock:
  - Interleave valid_in=0 cycles inside 8'h5A -> same output as without gaps, pulse delayed by the gap count.
  - Assert RESET mid-byte -> all outputs 0 on that edge; relock requires a full COMMA_COUNT sequence.

Source files
------------

// File: rtl/ser2par_sync.sv
// rtl/ser2par_sync.sv - comma-aligned serial-to-parallel deserialiser
// Hunts for COMMA bit-by-bit, locks after COMMA_COUNT aligned commas, then emits MSB-first words.
module ser2par_sync #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] COMMA       = 8'hBC,
   parameter int               COMMA_COUNT = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             D,
   input  logic             valid_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             active
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [3:0]    CC   = 4'(COMMA_COUNT);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sr, next_sr;
   logic [CW-1:0]    bit_cnt, bit_cnt_nxt, bit_cnt_inc;
   logic [3:0]       bc_cnt, bc_cnt_nxt, bc_cnt_inc;
   logic [WIDTH-1:0] data_nxt;
   logic             valid_nxt;
   logic             is_comma, boundary;

   // All compares look at the word including the bit arriving on this edge.
   always_comb begin
      next_sr     = {sr[WIDTH-2:0], D};
      is_comma    = (next_sr == COMMA);
      boundary    = (bit_cnt == LAST);
      bit_cnt_inc = boundary ? '0 : bit_cnt + 1'b1;
      bc_cnt_inc  = (bc_cnt >= CC) ? bc_cnt : bc_cnt + 4'd1;

      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      bc_cnt_nxt  = bc_cnt;
      data_nxt    = data_out;
      valid_nxt   = 1'b0;

      if (valid_in) begin
         case (state)
            SEARCH: begin
               if (is_comma) begin
                  bit_cnt_nxt = '0;
                  bc_cnt_nxt  = 4'd1;
                  state_nxt   = (CC == 4'd1) ? LOCKED : ALIGN;
               end
            end
            ALIGN: begin
               bit_cnt_nxt = bit_cnt_inc;
               if (boundary) begin
                  if (is_comma) begin
                     bc_cnt_nxt = bc_cnt_inc;
                     if (bc_cnt_inc == CC)
                        state_nxt = LOCKED;
                  end else begin
                     bc_cnt_nxt = 4'd0;
                     state_nxt  = SEARCH;
                  end
               end
            end
            LOCKED: begin
               bit_cnt_nxt = bit_cnt_inc;
               if (boundary) begin
                  data_nxt  = next_sr;
                  valid_nxt = !is_comma;
               end
            end
            default: begin
               state_nxt = SEARCH;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= SEARCH;
         sr        <= '0;
         bit_cnt   <= '0;
         bc_cnt    <= 4'd0;
         data_out  <= '0;
         valid_out <= 1'b0;
         active    <= 1'b0;
      end else begin
         if (valid_in)
            sr <= next_sr;
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         bc_cnt    <= bc_cnt_nxt;
         data_out  <= data_nxt;
         valid_out <= valid_nxt;
         active    <= (state_nxt == LOCKED);
      end
   end

endmodule

// File: tb/tb_ser2par_sync.sv
// tb/tb_ser2par_sync.sv - self-checking bench for ser2par_sync
// Expected data words are queued as stimulus is sent and matched against observed valid_out pulses.
module tb_ser2par_sync;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       D = 1'b0;
   logic       valid_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];

   ser2par_sync #(.WIDTH(8), .COMMA(8'hBC), .COMMA_COUNT(4)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .D        (D),
      .valid_in (valid_in),
      .data_out (data_out),
      .valid_out(valid_out),
      .active   (active)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (valid_out === 1'b1)
         obs_q.push_back(data_out);
   end

   task automatic send_bit(input logic d, input logic v);
      D = d;
      valid_in = v;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      for (int c = 0; c < 2; c++) begin
         send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         checks++;
         if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset cycle %0d: got data=%h valid=%b active=%b want 00/0/0",
                     c, data_out, valid_out, active);
         end
      end
      RESET = 1'b0;
   endtask

   task automatic test_lock_odd_offset();
      logic [34:0] seq;
      seq = {3'b101, 32'hBCBC_BCBC};
      for (int i = 34; i >= 0; i--) begin
         send_bit(seq[i], 1'b1);
         checks++;
         if (active !== (i == 0) || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL lock_odd bit %0d: got active=%b valid=%b want active=%b valid=0",
                     35 - i, active, valid_out, (i == 0));
         end
      end
   endtask

   task automatic test_data_after_lock();
      logic [7:0] bytes [2];
      bytes[0] = 8'hA5;
      bytes[1] = 8'h3C;
      for (int n = 0; n < 2; n++) begin
         exp_q.push_back(bytes[n]);
         for (int b = 7; b >= 0; b--) begin
            send_bit(bytes[n][b], 1'b1);
            if (b == 0) begin
               checks++;
               if (valid_out !== 1'b1 || data_out !== bytes[n]) begin
                  errors++;
                  $display("FAIL data_lsb byte %0d: got valid=%b data=%h want 1/%h",
                           n, valid_out, data_out, bytes[n]);
               end
            end else begin
               checks++;
               if (valid_out !== 1'b0) begin
                  errors++;
                  $display("FAIL data_midword byte %0d bit %0d: got valid=%b want 0", n, b, valid_out);
               end
            end
         end
      end
   endtask

   task automatic test_idle_locked();
      logic [7:0] comma;
      comma = 8'hBC;
      for (int b = 7; b >= 0; b--)
         send_bit(comma[b], 1'b1);
      checks++;
      if (data_out !== 8'hBC || valid_out !== 1'b0 || active !== 1'b1) begin
         errors++;
         $display("FAIL idle: got data=%h valid=%b active=%b want bc/0/1", data_out, valid_out, active);
      end
   endtask

   task automatic test_gaps();
      logic [7:0] w;
      w = 8'h5A;
      exp_q.push_back(w);
      for (int b = 7; b >= 0; b--) begin
         for (int g = 0; g < (b % 3); g++) begin
            send_bit(1'($urandom_range(0, 1)), 1'b0);
            checks++;
            if (valid_out !== 1'b0 || active !== 1'b1) begin
               errors++;
               $display("FAIL gap bit %0d: got valid=%b active=%b want 0/1", b, valid_out, active);
            end
         end
         send_bit(w[b], 1'b1);
         checks++;
         if (valid_out !== (b == 0)) begin
            errors++;
            $display("FAIL gap_pulse bit %0d: got valid=%b want %b", b, valid_out, (b == 0));
         end
      end
      checks++;
      if (data_out !== 8'h5A) begin
         errors++;
         $display("FAIL gap_data: got %h want 5a", data_out);
      end
      send_bit(1'b1, 1'b0);
      checks++;
      if (valid_out !== 1'b0 || data_out !== 8'h5A) begin
         errors++;
         $display("FAIL gap_after: got valid=%b data=%h want 0/5a", valid_out, data_out);
      end
   endtask

   task automatic test_reset_mid_lock();
      logic [7:0] w;
      logic [31:0] commas;
      w = 8'hA5;
      commas = 32'hBCBC_BCBC;
      for (int b = 7; b >= 5; b--)
         send_bit(w[b], 1'b1);
      RESET = 1'b1;
      send_bit(1'b1, 1'b1);
      checks++;
      if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got data=%h valid=%b active=%b want 00/0/0",
                  data_out, valid_out, active);
      end
      RESET = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         send_bit(commas[i], 1'b1);
         checks++;
         if (active !== (i == 0) || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL relock bit %0d: got active=%b valid=%b want active=%b valid=0",
                     32 - i, active, valid_out, (i == 0));
         end
      end
   endtask

   task automatic test_align_failure();
      logic [31:0] bad;
      logic [31:0] good;
      bad  = 32'hBCBC_BC00;
      good = 32'hBCBC_BCBC;
      RESET = 1'b1;
      send_bit(1'b0, 1'b1);
      RESET = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         send_bit(bad[i], 1'b1);
         checks++;
         if (active !== 1'b0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL align_fail bit %0d: got active=%b valid=%b want 0/0",
                     32 - i, active, valid_out);
         end
      end
      for (int i = 31; i >= 0; i--) begin
         send_bit(good[i], 1'b1);
         checks++;
         if (active !== (i == 0)) begin
            errors++;
            $display("FAIL align_relock bit %0d: got active=%b want %b", 32 - i, active, (i == 0));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w;
      for (int n = 0; n < 4; n++) begin
         do w = 8'($urandom_range(0, 255)); while (w == 8'hBC);
         exp_q.push_back(w);
         for (int b = 7; b >= 0; b--)
            send_bit(w[b], 1'b1);
         checks++;
         if (valid_out !== 1'b1 || data_out !== w) begin
            errors++;
            $display("FAIL b2b byte %0d: got valid=%b data=%h want 1/%h", n, valid_out, data_out, w);
         end
      end
   endtask

   task automatic test_scoreboard();
      logic [7:0] e;
      logic [7:0] o;
      @(negedge CLK);
      #1;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL sb_count: got %0d words want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL sb_word: got %h want %h", o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock_odd_offset();
      test_data_after_lock();
      test_idle_locked();
      test_gaps();
      test_reset_mid_lock();
      test_align_failure();
      test_back_to_back();
      test_scoreboard();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
